// File: rtl/fm_sched_pkg.sv
// Shared types and constants for the frame-memory cycle scheduler.
// The owner encoding matches SLOT_IDX. The donation order lists the highest priority first.
package fm_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_IV_WR = 2'd0,
    SLOT_IV_RD = 2'd1,
    SLOT_OV_RD = 2'd2,
    SLOT_OV_WR = 2'd3
  } slot_e;

  localparam int SLOT_LEN_MIN = 4;
  localparam int SLOT_LEN_MAX = 255;

  localparam slot_e DONATE_PRIO [4] = '{SLOT_OV_RD, SLOT_IV_RD, SLOT_IV_WR, SLOT_OV_WR};

  function automatic logic [3:0] slot_onehot(slot_e s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/fm_cycle_sched_if.sv
// Request, strobe and frame-status bundle between the scheduler and its requesters.
// The scheduler connects through the slave modport. The requesters and frame logic connect through the master modport.
interface fm_cycle_sched_if;

  logic       VSYNC;
  logic       FREEZE;
  logic       IV_WR_REQ;
  logic       IV_RD_REQ;
  logic       OV_RD_REQ;
  logic       OV_WR_REQ;
  logic       FM_IV_WR_CYCLE;
  logic       FM_IV_RD_CYCLE;
  logic       FM_OV_RD_CYCLE;
  logic       FM_OV_WR_CYCLE;
  logic       FM_CYCLE_STP_ADV;
  logic [1:0] SLOT_IDX;
  logic       FRAME_ALT;
  logic       FRAME_ALT_FRZ;
  logic       VSYNC_ERR;

  modport master (
    output VSYNC, FREEZE, IV_WR_REQ, IV_RD_REQ, OV_RD_REQ, OV_WR_REQ,
    input  FM_IV_WR_CYCLE, FM_IV_RD_CYCLE, FM_OV_RD_CYCLE, FM_OV_WR_CYCLE,
    input  FM_CYCLE_STP_ADV, SLOT_IDX, FRAME_ALT, FRAME_ALT_FRZ, VSYNC_ERR
  );

  modport slave (
    input  VSYNC, FREEZE, IV_WR_REQ, IV_RD_REQ, OV_RD_REQ, OV_WR_REQ,
    output FM_IV_WR_CYCLE, FM_IV_RD_CYCLE, FM_OV_RD_CYCLE, FM_OV_WR_CYCLE,
    output FM_CYCLE_STP_ADV, SLOT_IDX, FRAME_ALT, FRAME_ALT_FRZ, VSYNC_ERR
  );

endinterface

// File: rtl/fm_slot_timer.sv
// Slot cycle counter. It flags the last cycle of each slot (the boundary).
// The step-advance output is registered and is high on slot cycle SLOT_LEN-2.
module fm_slot_timer
  import fm_sched_pkg::*;
#(
  parameter int SLOT_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bnd,
  output logic o_stp_adv
);

  localparam int LEN = (SLOT_LEN < SLOT_LEN_MIN) ? SLOT_LEN_MIN :
                       (SLOT_LEN > SLOT_LEN_MAX) ? SLOT_LEN_MAX : SLOT_LEN;
  localparam logic [7:0] LAST    = 8'(LEN - 1);
  localparam logic [7:0] STP_PRE = 8'(LEN - 3);

  logic [7:0] r_cnt;
  logic       r_stp_adv;

  // Set r_stp_adv one cycle early so that the pulse itself comes out of a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= 8'd0;
      r_stp_adv <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
      r_stp_adv <= (r_cnt == STP_PRE);
    end
  end

  assign o_bnd     = (r_cnt == LAST);
  assign o_stp_adv = r_stp_adv;

endmodule

// File: rtl/fm_cycle_sched.sv
// Frame-memory cycle scheduler: rotates four slot owners, VSYNC realigns to slot 0.
// Optional FM_SLOT_DONATE_EN hands idle slots to the highest-priority pending requester.
module fm_cycle_sched
  import fm_sched_pkg::*;
#(
  parameter int SLOT_LEN = 8
) (
  input  logic             CLK,
  input  logic             RST,
  fm_cycle_sched_if.slave  bus
);

  logic       w_bnd;
  logic       w_stp_adv;
  logic [3:0] w_req;
  slot_e      w_idx_nxt;
  logic [3:0] w_grant_nxt;

  slot_e      r_slot_idx;
  logic [3:0] r_grant;
  logic       r_resync_pend;
  logic       r_frame_alt;
  logic       r_frame_alt_frz;
  logic       r_vsync_err;

  fm_slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .o_bnd     (w_bnd),
    .o_stp_adv (w_stp_adv)
  );

  assign w_req     = {bus.OV_WR_REQ, bus.OV_RD_REQ, bus.IV_RD_REQ, bus.IV_WR_REQ};
  assign w_idx_nxt = r_resync_pend ? SLOT_IV_WR : slot_e'(r_slot_idx + 2'd1);

  always_comb begin
    w_grant_nxt = w_req & slot_onehot(w_idx_nxt);
`ifdef FM_SLOT_DONATE_EN
    // Walk from the lowest priority to the highest so that the highest pending requester wins.
    if (w_grant_nxt == 4'b0000) begin
      for (int i = 3; i >= 0; i--) begin
        if (w_req[DONATE_PRIO[i]]) w_grant_nxt = slot_onehot(DONATE_PRIO[i]);
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slot_idx      <= SLOT_IV_WR;
      r_grant         <= 4'b0000;
      r_resync_pend   <= 1'b0;
      r_frame_alt     <= 1'b0;
      r_frame_alt_frz <= 1'b0;
      r_vsync_err     <= 1'b0;
    end else begin
      if (w_bnd) begin
        r_slot_idx <= w_idx_nxt;
        r_grant    <= w_grant_nxt;
      end
      if (w_bnd && r_resync_pend) begin
        r_frame_alt <= ~r_frame_alt;
        if (!bus.FREEZE) r_frame_alt_frz <= ~r_frame_alt;
      end
      // A VSYNC that arrives while a resync is still pending is dropped and flagged.
      if (bus.VSYNC && r_resync_pend) r_vsync_err <= 1'b1;
      if (bus.VSYNC && !r_resync_pend) r_resync_pend <= 1'b1;
      else if (w_bnd)                  r_resync_pend <= 1'b0;
    end
  end

  assign bus.FM_IV_WR_CYCLE   = r_grant[SLOT_IV_WR];
  assign bus.FM_IV_RD_CYCLE   = r_grant[SLOT_IV_RD];
  assign bus.FM_OV_RD_CYCLE   = r_grant[SLOT_OV_RD];
  assign bus.FM_OV_WR_CYCLE   = r_grant[SLOT_OV_WR];
  assign bus.FM_CYCLE_STP_ADV = w_stp_adv;
  assign bus.SLOT_IDX         = r_slot_idx;
  assign bus.FRAME_ALT        = r_frame_alt;
  assign bus.FRAME_ALT_FRZ    = r_frame_alt_frz;
  assign bus.VSYNC_ERR        = r_vsync_err;

endmodule

// File: tb/tb_fm_cycle_sched.sv
// Bench for fm_cycle_sched with SLOT_LEN=8, built without FM_SLOT_DONATE_EN.
// Table-driven request patterns checked cycle by cycle, plus hand-written VSYNC and reset sequences.
module tb_fm_cycle_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fm_cycle_sched_if ifc ();

  fm_cycle_sched #(.SLOT_LEN(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int k      = 0;

  typedef struct packed {
    logic [3:0] stb;
    logic [1:0] idx;
    logic       stp;
  } obs_t;

  typedef struct packed {
    logic [3:0]      req;
    logic [3:0][3:0] exp_stb;
  } vec_t;

  obs_t sb_q [$];
  vec_t tbl [4];

  function automatic logic [3:0] stb_now();
    return {ifc.FM_OV_WR_CYCLE, ifc.FM_OV_RD_CYCLE, ifc.FM_IV_RD_CYCLE, ifc.FM_IV_WR_CYCLE};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at k=%0d: actual=%0d expected=%0d", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_k(input int t);
    while (k < t) tick();
  endtask

  task automatic set_req(input logic [3:0] r);
    ifc.IV_WR_REQ = r[0];
    ifc.IV_RD_REQ = r[1];
    ifc.OV_RD_REQ = r[2];
    ifc.OV_WR_REQ = r[3];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    k = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"},  int'(stb_now()),            0);
    chk({tag, "_idx"},  int'(ifc.SLOT_IDX),         0);
    chk({tag, "_stp"},  int'(ifc.FM_CYCLE_STP_ADV), 0);
    chk({tag, "_alt"},  int'(ifc.FRAME_ALT),        0);
    chk({tag, "_frz"},  int'(ifc.FRAME_ALT_FRZ),    0);
    chk({tag, "_err"},  int'(ifc.VSYNC_ERR),        0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.VSYNC  = 1'b0;
    ifc.FREEZE = 1'b0;
    set_req(4'b0000);

    // Each row gives the request vector and the expected strobe vector for owners 3..0.
    tbl[0] = '{req: 4'b1111, exp_stb: {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
    tbl[1] = '{req: 4'b0100, exp_stb: {4'b0000, 4'b0100, 4'b0000, 4'b0000}};
    tbl[2] = '{req: 4'b1010, exp_stb: {4'b1000, 4'b0000, 4'b0010, 4'b0000}};
    tbl[3] = '{req: 4'b0001, exp_stb: {4'b0000, 4'b0000, 4'b0000, 4'b0001}};

    do_reset();
    chk_all_zero("reset");

    for (int e = 0; e < 4; e++) begin
      do_reset();
      set_req(tbl[e].req);
      for (int n = 0; n < 64; n++) begin
        int   kn;
        int   s;
        obs_t ex;
        obs_t got;
        kn = k + 1;
        s  = kn / 8;
        ex.idx = 2'(s % 4);
        ex.stb = (s == 0) ? 4'b0000 : tbl[e].exp_stb[ex.idx];
        ex.stp = ((kn % 8) == 6);
        sb_q.push_back(ex);
        tick();
        got = sb_q.pop_front();
        chk($sformatf("tbl%0d_stb", e), int'(stb_now()),            int'(got.stb));
        chk($sformatf("tbl%0d_idx", e), int'(ifc.SLOT_IDX),         int'(got.idx));
        chk($sformatf("tbl%0d_stp", e), int'(ifc.FM_CYCLE_STP_ADV), int'(got.stp));
      end
    end
    set_req(4'b0000);

    // Three resyncs, each with VSYNC on cnt=3. FREEZE is held high only at the first resync boundary.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      logic [2:0] frz_pat;
      logic [2:0] alt_exp;
      logic [2:0] frz_exp;
      frz_pat = 3'b001;
      alt_exp = 3'b101;
      frz_exp = 3'b100;
      wait_k(19 + 8 * r);
      ifc.FREEZE = frz_pat[r];
      ifc.VSYNC  = 1'b1;
      tick();
      ifc.VSYNC  = 1'b0;
      wait_k(23 + 8 * r);
      chk($sformatf("rs%0d_idx_pre", r), int'(ifc.SLOT_IDX), (r == 0) ? 2 : 0);
      tick();
      chk($sformatf("rs%0d_idx", r), int'(ifc.SLOT_IDX),      0);
      chk($sformatf("rs%0d_alt", r), int'(ifc.FRAME_ALT),     int'(alt_exp[r]));
      chk($sformatf("rs%0d_frz", r), int'(ifc.FRAME_ALT_FRZ), int'(frz_exp[r]));
      chk($sformatf("rs%0d_err", r), int'(ifc.VSYNC_ERR),     0);
    end
    ifc.FREEZE = 1'b0;
    wait_k(46);
    chk("rs_stp_after", int'(ifc.FM_CYCLE_STP_ADV), 1);
    wait_k(48);
    chk("rs_idx_rotate", int'(ifc.SLOT_IDX), 1);

    // Two VSYNC pulses two clocks apart in slot 2 cause a single resync and set the sticky error.
    do_reset();
    wait_k(17);
    ifc.VSYNC = 1'b1;
    tick();
    ifc.VSYNC = 1'b0;
    chk("dv_err_first", int'(ifc.VSYNC_ERR), 0);
    tick();
    ifc.VSYNC = 1'b1;
    tick();
    ifc.VSYNC = 1'b0;
    chk("dv_err_set", int'(ifc.VSYNC_ERR), 1);
    wait_k(24);
    chk("dv_idx_resync", int'(ifc.SLOT_IDX),  0);
    chk("dv_alt",        int'(ifc.FRAME_ALT), 1);
    wait_k(32);
    chk("dv_idx_single", int'(ifc.SLOT_IDX),  1);
    chk("dv_alt_hold",   int'(ifc.FRAME_ALT), 1);
    wait_k(40);
    chk("dv_err_sticky", int'(ifc.VSYNC_ERR), 1);

    // Reset in the middle of a granted slot, after the frame and error flags have been set.
    do_reset();
    set_req(4'b1111);
    wait_k(1);
    ifc.VSYNC = 1'b1;
    tick();
    ifc.VSYNC = 1'b0;
    tick();
    ifc.VSYNC = 1'b1;
    tick();
    ifc.VSYNC = 1'b0;
    wait_k(8);
    chk("mr_idx_resync", int'(ifc.SLOT_IDX),      0);
    chk("mr_alt_pre",    int'(ifc.FRAME_ALT),     1);
    chk("mr_frz_pre",    int'(ifc.FRAME_ALT_FRZ), 1);
    chk("mr_err_pre",    int'(ifc.VSYNC_ERR),     1);
    wait_k(12);
    chk("mr_stb_pre", int'(stb_now()), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("mr_rst");
    rst = 1'b0;
    k = 0;
    for (int n = 1; n < 8; n++) begin
      tick();
      chk("mr_slot0_idle", int'(stb_now()), 0);
    end
    tick();
    chk("mr_slot1_stb", int'(stb_now()),    2);
    chk("mr_slot1_idx", int'(ifc.SLOT_IDX), 1);
    set_req(4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_cycle_sched.md
# fm_cycle_sched

Frame-memory cycle scheduler for the video processing path. Time-division multiplexes the single frame-memory port among four requesters: input-video write, input-video read, output-video read and output-video write. Generates the per-slot cycle strobes and the step-advance pulse consumed by the `fm_in`/`fm_out` engines. Also generates the frame-alternate flag and its freezable copy on vertical sync.

## Interface
- `SLOT_LEN`, default 8: clocks per slot; legal range 4..255.
- `CLK` in 1: system clock; all logic rises on it.
- `RST` in 1: synchronous, active-high reset.
- `VSYNC` in 1: one-clock frame-start pulse.
- `FREEZE` in 1: level; holds `FRAME_ALT_FRZ`.
- `IV_WR_REQ`, `IV_RD_REQ`, `OV_RD_REQ`, `OV_WR_REQ` in 1 each: level requests, held until served.
- `FM_IV_WR_CYCLE`, `FM_IV_RD_CYCLE`, `FM_OV_RD_CYCLE`, `FM_OV_WR_CYCLE` out 1 each: grant strobes, high for the whole granted slot; at most one high at a time.
- `FM_CYCLE_STP_ADV` out 1: one-clock pulse in slot cycle `SLOT_LEN-2`.
- `SLOT_IDX` out 2: owner index of the current slot (0 = IV_WR, 1 = IV_RD, 2 = OV_RD, 3 = OV_WR).
- `FRAME_ALT`, `FRAME_ALT_FRZ` out 1 each: frame parity, and its freezable copy.
- `VSYNC_ERR` out 1: sticky; set when `VSYNC` arrives while a resync is already pending.

## Operation
- Slot counter `cnt` runs 0..`SLOT_LEN-1` and wraps.
- At the boundary (`cnt==SLOT_LEN-1`):
  - `SLOT_IDX` advances mod 4.
  - The grant for the new slot is decided from the request of its owner, sampled in that same cycle.
- Registered strobe: the owner's `FM_*_CYCLE` is high for all `SLOT_LEN` cycles of the new slot if its request was high at the boundary. Otherwise all strobes are low for that slot (idle).
- A requester drops its request once it sees its strobe. A request still high at a later boundary of its own slot is granted again.
- VSYNC:
  - Sets `resync_pend`.
  - At the next boundary, `SLOT_IDX` goes to 0 instead of advancing, and `resync_pend` clears.
  - At that same boundary, `FRAME_ALT` toggles.
  - `FRAME_ALT_FRZ` loads the new `FRAME_ALT` there unless `FREEZE` is high at that cycle.
- VSYNC arriving while `resync_pend` is already set: ignored, and `VSYNC_ERR` sets.
- VSYNC arriving on the boundary cycle itself: applies at the following boundary.
- `RST`:
  - Clears `cnt`, `SLOT_IDX`, all strobes, `FM_CYCLE_STP_ADV`, `FRAME_ALT`, `FRAME_ALT_FRZ`, `resync_pend` and `VSYNC_ERR` to 0.
  - Asserted mid-slot, it drops an active strobe on the next edge.
  - The first slot after reset (slot 0) is always idle.

## Timing
- Request-to-strobe latency is 1 to 4·`SLOT_LEN` clocks, depending on slot phase.
- Strobe rises on slot cycle 0 and falls after slot cycle `SLOT_LEN-1`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `FM_CYCLE_STP_ADV` precedes every boundary by exactly one clock, including idle slots and resync boundaries.
- VSYNC-to-resync latency is at most `SLOT_LEN` clocks.
- Rotation period without VSYNC is 4·`SLOT_LEN`.

## Configuration
- `FM_SLOT_DONATE_EN` defined:
  - An idle slot (owner request low at the boundary) is donated to another pending requester.
  - Fixed priority for donation: OV_RD > IV_RD > IV_WR > OV_WR.
  - The donee's strobe is high for the slot; `SLOT_IDX` still shows the nominal owner.
- `FM_SLOT_DONATE_EN` undefined: idle slots stay idle, with all strobes low.

## Structure
- Shared package `fm_sched_pkg`:
  - Slot-owner enum (`SLOT_IV_WR`=0 … `SLOT_OV_WR`=3).
  - `SLOT_LEN_MIN`=4.
  - Donation priority order constant.
- Sub-module `fm_slot_timer`: the `cnt` counter, with boundary and `stp_adv` flags.
- Grant logic, the VSYNC/frame-parity logic and the error flag stay in the top module.

## Test plan
- Reset, then all four requests held high, `SLOT_LEN`=8 → strobes cycle IV_RD, OV_RD, OV_WR, IV_WR, each high 8 clocks; slot 0 after reset idle; `FM_CYCLE_STP_ADV` at `cnt`=6 of every slot.
- Only `OV_RD_REQ` high, macro undefined → `FM_OV_RD_CYCLE` high 8 of every 32 clocks, other slots all-low.
- Only `OV_RD_REQ` high, macro defined → `FM_OV_RD_CYCLE` high continuously; `SLOT_IDX` still rotates 0..3.
- VSYNC at `cnt`=3 of slot 2 → next boundary `SLOT_IDX`=0 and `FRAME_ALT` 0→1; with `FREEZE`=1 there, `FRAME_ALT_FRZ` stays 0.
- Two VSYNC pulses 2 clocks apart within one slot → single resync; `VSYNC_ERR`=1 and it stays high until `RST`.
- `RST` asserted at `cnt`=4 of a granted slot → strobe low on the next edge; all outputs 0; rotation restarts at slot 0, idle.
